// File: rtl/engine_rr_arbiter_pkg.sv
// Shared definitions for the engine round-robin arbiter: FSM state encoding
// and the default watchdog limit.
package arb_defs;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        ACK   = 3'd3,
        ERR   = 3'd4
    } arb_state_t;

    localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/engine_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit found scanning
// upward from ptr, wrapping at NREQ-1.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [PW-1:0]   idx,
    output logic            valid
);

    always_comb begin
        int unsigned j;
        logic [PW-1:0] jw;
        j     = 0;
        jw    = '0;
        idx   = '0;
        valid = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            jw = PW'(j);
            if (!valid && req[jw]) begin
                valid = 1'b1;
                idx   = jw;
            end
        end
    end

endmodule

// File: rtl/engine_rr_arbiter.sv
// Round-robin arbiter sharing one compute engine among NREQ requesters,
// with a watchdog that aborts an engine job that never completes.
module engine_rr_arbiter
    import arb_defs::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            eng_done,
    output logic            eng_start,
    output logic [NREQ-1:0] grant,
    output logic [NREQ-1:0] ack,
    output logic            timeout_err,
    output logic            busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    arb_state_t    state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] owner;
    logic [PW-1:0] pick_idx;
    logic          pick_valid;
    logic [TW-1:0] wdog;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // Outputs are registered alongside the state so each one already
    // carries the value decoded from the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            owner       <= '0;
            wdog        <= '0;
            eng_start   <= 1'b0;
            grant       <= '0;
            ack         <= '0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            eng_start   <= 1'b0;
            ack         <= '0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner     <= pick_idx;
                        grant     <= NREQ'(1) << pick_idx;
                        eng_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    wdog  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // Completion takes precedence over an expiring watchdog.
                    if (eng_done) begin
                        ack   <= NREQ'(1) << owner;
                        state <= ACK;
                    end else if (wdog == TW'(TIMEOUT)) begin
                        timeout_err <= 1'b1;
                        state       <= ERR;
                    end else begin
                        wdog <= wdog + TW'(1);
                    end
                end
                ACK, ERR: begin
                    ptr   <= (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);
                    grant <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    grant <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
